// File: rtl/ecc_decode_arb.sv
// Two-requester round-robin front end for a shared Hamming(12,7) SEC-DED decoder.
// It registers one decoded response, counts corrected and uncorrectable words, and can halt on a double error.

module decode_hamming (
   input  logic [12:1] in_data,
   output logic [7:1]  out_data,
   output logic [3:0]  syn,
   output logic        se,
   output logic        de
);

   logic       par;
   logic [7:1] raw;
   logic [7:1] flip;

   // Check bits sit at positions 1, 2, 4 and 8. Bit 12 is the overall parity over the whole word.
   assign syn[0] = in_data[1] ^ in_data[3] ^ in_data[5] ^ in_data[7] ^ in_data[9] ^ in_data[11];
   assign syn[1] = in_data[2] ^ in_data[3] ^ in_data[6] ^ in_data[7] ^ in_data[10] ^ in_data[11];
   assign syn[2] = in_data[4] ^ in_data[5] ^ in_data[6] ^ in_data[7];
   assign syn[3] = in_data[8] ^ in_data[9] ^ in_data[10] ^ in_data[11];
   assign par    = ^in_data;

   // Odd parity means one bit flipped. If the syndrome then points past position 11, treat the word as uncorrectable.
   assign se = par && (syn <= 4'd11);
   assign de = (!par && (syn != 4'd0)) || (par && (syn > 4'd11));

   assign raw  = {in_data[11], in_data[10], in_data[9], in_data[7],
                  in_data[6],  in_data[5],  in_data[3]};
   assign flip = {7{se}} & {syn == 4'd11, syn == 4'd10, syn == 4'd9, syn == 4'd7,
                            syn == 4'd6,  syn == 4'd5,  syn == 4'd3};
   assign out_data = raw ^ flip;

endmodule

module ecc_decode_arb #(
   parameter int CNT_W       = 8,
   parameter int HALT_ON_DED = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [12:1]      req0_code,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [12:1]      req1_code,
   output logic             req1_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [7:1]       rsp_data,
   output logic [3:0]       rsp_syn,
   output logic             rsp_se,
   output logic             rsp_de,
   output logic [CNT_W-1:0] sec_cnt,
   output logic [CNT_W-1:0] ded_cnt,
   input  logic             clr_cnt,
   input  logic             clr_halt,
   output logic             halted
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t      state;
   logic        rr_ptr;
   logic        accept;
   logic        grant0;
   logic        grant1;
   logic        grant;
   logic [12:1] sel_code;
   logic [7:1]  dec_data;
   logic [3:0]  dec_syn;
   logic        dec_se;
   logic        dec_de;

   // NOTE: rst_n gates accept directly, so the readys are 0 the moment reset asserts, with no clock edge needed.
   assign accept = rst_n && (state == RUN) && (!rsp_valid || rsp_ready);

   assign grant1 = req1_valid && (!req0_valid || rr_ptr);
   assign grant0 = req0_valid && !grant1;
   assign grant  = accept && (grant0 || grant1);

   assign req0_ready = accept && grant0;
   assign req1_ready = accept && grant1;

   assign sel_code = grant1 ? req1_code : req0_code;

   decode_hamming u_dec (
      .in_data  (sel_code),
      .out_data (dec_data),
      .syn      (dec_syn),
      .se       (dec_se),
      .de       (dec_de)
   );

   // NOTE: every register here is updated with a non-blocking assignment. All reads in this block then see values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         halted    <= 1'b0;
         rr_ptr    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_syn   <= '0;
         rsp_se    <= 1'b0;
         rsp_de    <= 1'b0;
         sec_cnt   <= '0;
         ded_cnt   <= '0;
      end else begin
         // A capture overrides a drain in the same cycle, so rsp_valid stays high.
         if (grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant1;
            rsp_data  <= dec_data;
            rsp_syn   <= dec_syn;
            rsp_se    <= dec_se;
            rsp_de    <= dec_de;
            rr_ptr    <= !grant1;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end

         if (clr_cnt) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
         end else if (grant) begin
            if (dec_se && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + 1'b1;
            if (dec_de && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + 1'b1;
         end

         case (state)
            RUN: begin
               if (grant && dec_de && (HALT_ON_DED != 0)) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: begin
               if (clr_halt) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
